// File: rtl/enc_out.sv
// Quadrature encoder signal generator: synthesises A/B/index outputs at a programmable
// rate and direction, either continuously or for a commanded number of counts.
module enc_out #(
    parameter int unsigned MIN_QPERIOD = 4
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic [31:0] quarter_period,
    input  logic        enc_dir_cmd,
    input  logic [15:0] counts_per_index,
    input  logic        run_continuous,
    input  logic        start,
    input  logic [31:0] move_counts,
    input  logic        abort,
    input  logic        reset_enc_out_counts,
    output logic        enca_out,
    output logic        encb_out,
    output logic        enci_out,
    output logic [31:0] enc_out_counts,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StMove} state_e;

    state_e      state;
    logic [1:0]  phase;
    logic [31:0] timer;
    logic [31:0] remaining;
    logic [15:0] idx_cnt;
    logic        move_dir;

    logic [31:0] qp_eff;
    logic        step_due;
    logic        do_step;
    logic        step_dir;
    logic [1:0]  phase_step;
    logic [15:0] idx_step;
    logic [15:0] idx_d;

    always_comb begin
        qp_eff   = (quarter_period < 32'(MIN_QPERIOD)) ? 32'(MIN_QPERIOD) : quarter_period;
        step_due = (state != StIdle) && (quarter_period != 32'd0) && (timer >= qp_eff);
        // Clear and abort/exit outrank a step that would otherwise fire on the same edge.
        do_step  = !reset_enc_out_counts && !abort && step_due &&
                   ((state == StMove) || run_continuous);
        step_dir = (state == StMove) ? move_dir : enc_dir_cmd;

        // Phase is {B,A}; each step toggles exactly one channel.
        phase_step = 2'b00;
        case (phase)
            2'b00:   phase_step = step_dir ? 2'b01 : 2'b10;
            2'b01:   phase_step = step_dir ? 2'b11 : 2'b00;
            2'b11:   phase_step = step_dir ? 2'b10 : 2'b01;
            default: phase_step = step_dir ? 2'b00 : 2'b11;
        endcase

        idx_step = 16'd0;
        if (counts_per_index == 16'd0 || idx_cnt >= counts_per_index) begin
            idx_step = 16'd0;
        end else if (step_dir) begin
            idx_step = (idx_cnt == counts_per_index - 16'd1) ? 16'd0 : idx_cnt + 16'd1;
        end else begin
            idx_step = (idx_cnt == 16'd0) ? counts_per_index - 16'd1 : idx_cnt - 16'd1;
        end

        idx_d = idx_cnt;
        if (reset_enc_out_counts) begin
            idx_d = 16'd0;
        end else if (do_step) begin
            idx_d = idx_step;
        end
    end

    always_ff @(posedge xclk or negedge reset) begin
        if (!reset) begin
            state          <= StIdle;
            phase          <= 2'b00;
            timer          <= 32'd1;
            remaining      <= 32'd0;
            idx_cnt        <= 16'd0;
            move_dir       <= 1'b0;
            enc_out_counts <= 32'd0;
            enci_out       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done     <= 1'b0;
            idx_cnt  <= idx_d;
            enci_out <= (counts_per_index != 16'd0) && (idx_d == 16'd0);
            if (reset_enc_out_counts) begin
                state          <= StIdle;
                phase          <= 2'b00;
                timer          <= 32'd0;
                enc_out_counts <= 32'd0;
                busy           <= 1'b0;
            end else if (do_step) begin
                phase          <= phase_step;
                enc_out_counts <= step_dir ? enc_out_counts + 32'd1 : enc_out_counts - 32'd1;
                timer          <= 32'd1;
                if (state == StMove) begin
                    remaining <= remaining - 32'd1;
                    if (remaining == 32'd1) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end else begin
                case (state)
                    StIdle: begin
                        if (run_continuous) begin
                            state <= StRun;
                            timer <= 32'd1;
                        end else if (start) begin
                            if (move_counts != 32'd0) begin
                                state     <= StMove;
                                remaining <= move_counts;
                                move_dir  <= enc_dir_cmd;
                                busy      <= 1'b1;
                                timer     <= 32'd1;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    StRun: begin
                        if (!run_continuous || abort) begin
                            state <= StIdle;
                        end else if (quarter_period != 32'd0) begin
                            timer <= timer + 32'd1;
                        end
                    end
                    StMove: begin
                        if (abort) begin
                            state <= StIdle;
                            busy  <= 1'b0;
                        end else if (quarter_period != 32'd0) begin
                            timer <= timer + 32'd1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign enca_out = phase[0];
    assign encb_out = phase[1];

endmodule

// File: tb/tb_enc_out.sv
// Bench for enc_out: directed scenarios with fixed expectations, then randomized
// stimulus checked cycle by cycle against a position-based reference model.
module tb_enc_out;

    logic        xclk = 1'b0;
    logic        reset;
    logic [31:0] quarter_period;
    logic        enc_dir_cmd;
    logic [15:0] counts_per_index;
    logic        run_continuous;
    logic        start;
    logic [31:0] move_counts;
    logic        abort;
    logic        reset_enc_out_counts;
    logic        enca_out;
    logic        encb_out;
    logic        enci_out;
    logic [31:0] enc_out_counts;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    enc_out #(.MIN_QPERIOD(4)) dut (
        .xclk                 (xclk),
        .reset                (reset),
        .quarter_period       (quarter_period),
        .enc_dir_cmd          (enc_dir_cmd),
        .counts_per_index     (counts_per_index),
        .run_continuous       (run_continuous),
        .start                (start),
        .move_counts          (move_counts),
        .abort                (abort),
        .reset_enc_out_counts (reset_enc_out_counts),
        .enca_out             (enca_out),
        .encb_out             (encb_out),
        .enci_out             (enci_out),
        .enc_out_counts       (enc_out_counts),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 xclk = ~xclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge xclk);
        #1;
    endtask

    task automatic apply_reset();
        start                = 1'b0;
        abort                = 1'b0;
        reset_enc_out_counts = 1'b0;
        run_continuous       = 1'b0;
        reset                = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    // Reference model: position is the primary state; phase is the Gray code of pos mod 4.
    logic [31:0] m_pos;
    int          m_mode;     // 0 idle, 1 continuous, 2 finite move
    int unsigned m_elapsed;  // edges since entry or last step
    int unsigned m_left;
    logic        m_dir;
    int          m_idx;
    logic        m_busy, m_done, m_enci;
    logic [1:0]  gray_tbl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic model_reset();
        m_pos = 0; m_mode = 0; m_elapsed = 0; m_left = 0; m_dir = 0;
        m_idx = 0; m_busy = 0; m_done = 0; m_enci = 0;
    endtask

    task automatic model_edge();
        int unsigned eff;
        int          c;
        logic        d;
        c = int'(counts_per_index);
        m_done = 0;
        if (reset_enc_out_counts) begin
            m_pos = 0; m_idx = 0; m_mode = 0; m_busy = 0;
        end else if (m_mode == 0) begin
            if (run_continuous) begin
                m_mode = 1; m_elapsed = 0;
            end else if (start) begin
                if (move_counts != 0) begin
                    m_mode = 2; m_left = move_counts; m_dir = enc_dir_cmd;
                    m_busy = 1; m_elapsed = 0;
                end else begin
                    m_done = 1;
                end
            end
        end else if (abort || (m_mode == 1 && !run_continuous)) begin
            m_mode = 0; m_busy = 0;
        end else if (quarter_period != 0) begin
            eff = (quarter_period < 4) ? 4 : quarter_period;
            if (m_elapsed + 1 >= eff) begin
                m_elapsed = 0;
                d = (m_mode == 2) ? m_dir : enc_dir_cmd;
                m_pos = d ? m_pos + 1 : m_pos - 1;
                if (c == 0 || m_idx >= c) m_idx = 0;
                else m_idx = (m_idx + (d ? 1 : c - 1)) % c;
                if (m_mode == 2) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = 0; m_busy = 0; m_done = 1;
                    end
                end
            end else begin
                m_elapsed++;
            end
        end
        m_enci = (c != 0) && (m_idx == 0);
    endtask

    logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] rev_seq [3] = '{2'b10, 2'b11, 2'b01};

    initial begin
        int          n, hi, mism, changes;
        int          rise[$];
        int          chg[$];
        logic        prev_i;
        logic [31:0] prev_c;
        logic [34:0] snap;

        reset = 1'b0;
        quarter_period = 10; enc_dir_cmd = 1; counts_per_index = 3;
        run_continuous = 0; start = 0; move_counts = 0; abort = 0;
        reset_enc_out_counts = 0;
        #3;
        check_eq("rst_a", enca_out, 0);
        check_eq("rst_b", encb_out, 0);
        check_eq("rst_i", enci_out, 0);
        check_eq("rst_cnt", enc_out_counts, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        apply_reset();

        // Forward finite move of 8 counts at 10 cycles per state
        counts_per_index = 0; quarter_period = 10; enc_dir_cmd = 1; move_counts = 8;
        start = 1; tick(); start = 0;
        check_eq("fwd_busy", busy, 1);
        for (int k = 0; k < 8; k++) begin
            repeat (9) tick();
            check_eq("fwd_early", enc_out_counts, k);
            tick();
            check_eq("fwd_phase", {encb_out, enca_out}, fwd_seq[k % 4]);
            check_eq("fwd_cnt", enc_out_counts, k + 1);
            check_eq("fwd_idx_off", enci_out, 0);
        end
        check_eq("fwd_done", done, 1);
        check_eq("fwd_busy_end", busy, 0);
        tick();
        check_eq("fwd_done_pulse", done, 0);

        // Reverse move of 3 from reset
        apply_reset();
        quarter_period = 6; enc_dir_cmd = 0; move_counts = 3;
        start = 1; tick(); start = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (6) tick();
            check_eq("rev_phase", {encb_out, enca_out}, rev_seq[k]);
        end
        check_eq("rev_cnt", enc_out_counts, 32'hFFFF_FFFD);
        check_eq("rev_done", done, 1);

        // Index every 4 counts at 5 cycles per state
        apply_reset();
        counts_per_index = 4; quarter_period = 5; enc_dir_cmd = 1; run_continuous = 1;
        tick();
        prev_i = enci_out; hi = 0; mism = 0;
        for (int i = 1; i <= 120; i++) begin
            tick();
            if (enci_out !== (enc_out_counts[1:0] == 2'b00)) mism++;
            if (enci_out && !prev_i) rise.push_back(i);
            if (enci_out) hi++;
            prev_i = enci_out;
        end
        check_eq("idx_align", mism, 0);
        check_eq("idx_high_cycles", hi, 30);
        check_eq("idx_rises", rise.size() >= 2, 1);
        if (rise.size() >= 2) check_eq("idx_period", rise[1] - rise[0], 20);
        run_continuous = 0; tick();

        // Clamp: qp=2 behaves as 4; then qp=0 holds
        apply_reset();
        counts_per_index = 0; quarter_period = 2; run_continuous = 1;
        tick();
        prev_c = enc_out_counts;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (enc_out_counts != prev_c) chg.push_back(i);
            prev_c = enc_out_counts;
        end
        check_eq("clamp_steps", chg.size() >= 2, 1);
        if (chg.size() >= 2) begin
            check_eq("clamp_first", chg[0], 4);
            check_eq("clamp_gap", chg[1] - chg[0], 4);
        end
        quarter_period = 0; tick();
        snap = {enc_out_counts, encb_out, enca_out, enci_out}; changes = 0;
        repeat (1000) begin
            tick();
            if ({enc_out_counts, encb_out, enca_out, enci_out} !== snap) changes++;
        end
        check_eq("hold_qp0", changes, 0);
        run_continuous = 0; tick();

        // Clear mid-move
        apply_reset();
        quarter_period = 4; move_counts = 10; enc_dir_cmd = 1;
        start = 1; tick(); start = 0;
        n = 0;
        while (enc_out_counts != 3 && n < 100) begin tick(); n++; end
        check_eq("clr_reach", enc_out_counts, 3);
        reset_enc_out_counts = 1; tick(); reset_enc_out_counts = 0;
        check_eq("clr_cnt", enc_out_counts, 0);
        check_eq("clr_phase", {encb_out, enca_out}, 0);
        check_eq("clr_busy", busy, 0);
        n = 0;
        repeat (60) begin tick(); if (done) n++; end
        check_eq("clr_no_done", n, 0);
        check_eq("clr_still0", enc_out_counts, 0);

        // Abort mid-move
        apply_reset();
        start = 1; tick(); start = 0;
        n = 0;
        while (enc_out_counts != 3 && n < 100) begin tick(); n++; end
        abort = 1; tick(); abort = 0;
        check_eq("abort_cnt", enc_out_counts, 3);
        check_eq("abort_busy", busy, 0);
        n = 0;
        repeat (60) begin tick(); if (done) n++; end
        check_eq("abort_no_done", n, 0);
        check_eq("abort_hold", enc_out_counts, 3);

        // Zero-length move
        apply_reset();
        move_counts = 0; start = 1; tick(); start = 0;
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        tick();
        check_eq("zero_done_pulse", done, 0);
        repeat (20) tick();
        check_eq("zero_no_step", enc_out_counts, 0);

        // Asynchronous reset mid-run
        apply_reset();
        quarter_period = 4; enc_dir_cmd = 1; run_continuous = 1;
        repeat (15) tick();
        check_eq("arst_pre", enc_out_counts, 3);
        reset = 0; #1;
        check_eq("arst_cnt", enc_out_counts, 0);
        check_eq("arst_ab", {encb_out, enca_out, enci_out}, 0);
        check_eq("arst_busy_done", {busy, done}, 0);
        reset = 1; run_continuous = 0; tick();

        // Wrap through 0xFFFFFFFF
        apply_reset();
        quarter_period = 4; enc_dir_cmd = 0; move_counts = 1;
        start = 1; tick(); start = 0;
        repeat (4) tick();
        check_eq("wrap_down", enc_out_counts, 32'hFFFF_FFFF);
        enc_dir_cmd = 1; start = 1; tick(); start = 0;
        repeat (4) tick();
        check_eq("wrap_up", enc_out_counts, 0);
        check_eq("wrap_phase", {encb_out, enca_out}, 0);

        // Randomized run against the reference model
        apply_reset();
        model_reset();
        quarter_period = 5; counts_per_index = 3; enc_dir_cmd = 1; move_counts = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            start = 0; abort = 0; reset_enc_out_counts = 0;
            if ($urandom_range(0, 49) == 0) quarter_period = $urandom_range(0, 9);
            if ($urandom_range(0, 99) == 0) counts_per_index = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) enc_dir_cmd = ~enc_dir_cmd;
            if ($urandom_range(0, 59) == 0) run_continuous = ~run_continuous;
            if ($urandom_range(0, 19) == 0) begin
                start = 1; move_counts = $urandom_range(0, 6);
            end
            if ($urandom_range(0, 149) == 0) abort = 1;
            if ($urandom_range(0, 199) == 0) reset_enc_out_counts = 1;
            @(posedge xclk);
            model_edge();
            #1;
            check_eq("rnd_cnt", enc_out_counts, m_pos);
            check_eq("rnd_phase", {encb_out, enca_out}, gray_tbl[m_pos[1:0]]);
            check_eq("rnd_idx", enci_out, m_enci);
            check_eq("rnd_busy", busy, m_busy);
            check_eq("rnd_done", done, m_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/enc_out.md
Name: enc_out

Overview:
Quadrature encoder signal generator. Synthesises enca/encb/enci digital outputs so that the test station can drive a unit under test, or loop back into the encoder input measurement block. Edge rate, direction and index spacing are programmable from host registers. The block runs either continuously or for a commanded number of counts, and reports its own position count. It sits in Fpga2 next to the encoder input block, clocked by clk75Mhz.

Parameters:
MIN_QPERIOD, 4, minimum xclk cycles per quadrature state; smaller programmed values are clamped to this. It must be at least 4 so the input de-bounce, which needs 3 stable samples, always passes each state.

Ports:
xclk  input  1  clk75Mhz; all logic on rising edge
reset  input  1  asynchronous, active-low; clears all state
quarter_period  input  32  xclk cycles per quadrature state; 0 = hold, no steps
enc_dir_cmd  input  1  1 = forward (count up), 0 = reverse
counts_per_index  input  16  counts between index pulses; 0 = index disabled
run_continuous  input  1  level; step indefinitely while high
start  input  1  one-cycle pulse; begin finite move
move_counts  input  32  number of steps for a finite move
abort  input  1  one-cycle pulse; stop immediately
reset_enc_out_counts  input  1  synchronous clear of position, phase, index and motion
enca_out  output  1  channel A (registered)
encb_out  output  1  channel B (registered)
enci_out  output  1  index (registered)
enc_out_counts  output  32  position count, two's complement, wraps
busy  output  1  high while in MOVE
done  output  1  one-cycle pulse when a finite move completes

Behaviour:
- Reset values: enca_out=0, encb_out=0, enci_out=0, enc_out_counts=0, busy=0, done=0. State is IDLE, phase is 00, timer is 1, index counter is 0.
- Phase uses the bit order {B,A}.
  - Forward sequence: 00→01→11→10→00.
  - Reverse sequence: 00→10→11→01→00.
  - Each step changes exactly one of A or B.
- Position: +1 per forward step, -1 per reverse step, modulo 2^32. A loopback into the encoder input block therefore reads an identical count.
- Step timer:
  - qp_eff = max(quarter_period, MIN_QPERIOD); if quarter_period=0, no steps occur.
  - The timer counts only in RUN or MOVE and is loaded to 1 on entering either state.
  - A step fires on the cycle where timer ≥ qp_eff. The timer then reloads to 1; otherwise it increments.
  - The first step comes qp_eff cycles after entry, and later steps are exactly qp_eff cycles apart.
  - quarter_period is sampled live. Lowering it below the current timer value causes a step on the next cycle.
- Outputs update on the same clock edge as the step. enca_out, encb_out, enci_out and enc_out_counts are all registered and change together.
- Index:
  - idx_cnt runs 0..counts_per_index-1. It increments on forward steps and decrements on reverse steps, wrapping in both directions.
  - enci_out = (counts_per_index≠0) && (idx_cnt==0), so the index is one quadrature state wide.
  - If counts_per_index changes so that idx_cnt ≥ counts_per_index, idx_cnt is reset to 0 on the next step.
- States:
  - IDLE:
    - reset_enc_out_counts has top priority.
    - Then, if run_continuous=1, go to RUN.
    - Else if start=1 and move_counts≠0, load remaining=move_counts, latch dir=enc_dir_cmd, set busy=1 and go to MOVE.
    - Else if start=1 and move_counts=0, pulse done on the next cycle and stay in IDLE.
  - RUN:
    - Direction is enc_dir_cmd, sampled at each step.
    - run_continuous=0 or abort returns to IDLE immediately; outputs hold their levels.
    - start is ignored.
  - MOVE:
    - Uses the latched direction.
    - remaining decrements on each step. On the step that makes remaining 0: go to IDLE, busy=0, done=1 for one cycle. The last step and done land on the same edge.
    - abort returns to IDLE with busy=0 and no done.
    - start and run_continuous are ignored.
- reset_enc_out_counts (synchronous, highest priority, in any state):
  - Clears position, idx_cnt and timer, and sets phase to 00.
  - Goes to IDLE with busy=0 and no done.
  - enci_out becomes 1 on the next cycle if counts_per_index≠0.
- Asynchronous reset mid-operation returns to the reset values immediately.

Test Plan:
1. Forward move: qp=10, cpi=0, dir=1, move_counts=8, start.
   - {B,A} = 01,11,10,00,01,11,10,00, with the first step 10 cycles after start and steps 10 cycles apart.
   - Final enc_out_counts=8; busy drops and done pulses on the 8th step edge.
   - Loopback into the encoder input block gives enc_counts=8, enc_dir=1.
2. Reverse move from reset: dir=0, move_counts=3, qp=6.
   - {B,A} = 10,11,01.
   - enc_out_counts=0xFFFFFFFD.
3. Index spacing: cpi=4, run_continuous=1, dir=1, qp=5.
   - enci_out is high at counts 0,4,8,…, each pulse 5 cycles wide with a 20-cycle period.
   - Loopback enci_period reads 20 when enc_index_freq_div=1.
4. Clamp and hold:
   - qp=2 gives a step every 4 cycles.
   - qp=0 with run_continuous=1 gives no steps, and the outputs stay constant for at least 1000 cycles.
5. Clear mid-move: move_counts=10, assert reset_enc_out_counts after 3 steps.
   - Next cycle: counts=0, A=B=0, busy=0, and done never pulses.
   - abort after 3 steps instead: counts=3, busy=0, no done.
6. Edge cases:
   - start with move_counts=0 gives done one cycle later and no steps.
   - Async reset asserted mid-RUN immediately gives all outputs 0.
   - Wrap: 1 forward step from 0xFFFFFFFF gives 0x00000000.
